// File: rtl/fifo_wrapper.sv
// First-word-fall-through FIFO with a registered-state valid/ready handshake on both sides.
// Defining FIFO_WRAPPER_OUTPUT_REG_EN adds an output register stage (2-cycle latency, DEPTH+1 capacity).
module fifo_wrapper #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid,
    input  logic             output_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             arr_valid;
    logic             wr_en;
    logic             rd_en;

    assign arr_valid = (count_q != '0);
    assign wr_en     = input_valid && ready_q;

`ifdef FIFO_WRAPPER_OUTPUT_REG_EN
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    // The output stage refills from the array in the same edge it is consumed.
    assign rd_en = arr_valid && (!out_valid_q || output_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!out_valid_q || output_ready) begin
            out_valid_d = arr_valid;
            out_data_d  = arr_valid ? mem_q[rd_ptr_q] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
`else
    assign rd_en        = arr_valid && output_ready;
    assign output_valid = arr_valid;
    assign output_data  = arr_valid ? mem_q[rd_ptr_q] : '0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_COUNT);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible because output_data is gated by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= input_data;
        end
    end

    assign input_ready = ready_q;

endmodule

// File: tb/tb_fifo_wrapper.sv
// Directed bench for fifo_wrapper (default build): queue-based reference model checked every
// falling edge, plus literal expectations for the key scenarios.
module tb_fifo_wrapper;

    localparam int WIDTH = 8;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] input_data;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_valid;
    logic             output_ready;

    int checks   = 0;
    int failures = 0;

    fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the expected ready flag.
    logic [WIDTH-1:0] mq[$];
    logic             m_rdy = 1'b0;
    logic             m_wr;
    logic             m_rd;
    logic [WIDTH-1:0] m_dummy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            m_wr = input_valid && m_rdy;
            m_rd = (mq.size() != 0) && output_ready;
            if (m_rd) m_dummy = mq.pop_front();
            if (m_wr) mq.push_back(input_data);
            m_rdy = (mq.size() != DEPTH);
        end
    end

    always @(negedge clk) begin
        check("cmp_input_ready", {31'd0, input_ready}, {31'd0, m_rdy});
        check("cmp_output_valid", {31'd0, output_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) check("cmp_output_data", {24'd0, output_data}, {24'd0, mq[0]});
        else                check("cmp_output_data", {24'd0, output_data}, 32'd0);
    end

    task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        input_valid  = iv;
        input_data   = d;
        output_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_input_ready", {31'd0, input_ready}, 32'd0);
        check("rst_output_valid", {31'd0, output_valid}, 32'd0);
        check("rst_output_data", {24'd0, output_data}, 32'd0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check("post_rst_ready", {31'd0, input_ready}, 32'd1);
        check("post_rst_empty", {31'd0, output_valid}, 32'd0);

        // Single word, 1-cycle fall-through latency, hold while not consumed.
        cyc(1'b1, 8'hA5, 1'b0);
        check("a5_valid", {31'd0, output_valid}, 32'd1);
        check("a5_data", {24'd0, output_data}, 32'hA5);
        cyc(1'b0, 8'h3C, 1'b0);
        cyc(1'b0, 8'h3C, 1'b0);
        check("a5_hold_data", {24'd0, output_data}, 32'hA5);
        cyc(1'b0, 8'h3C, 1'b1);
        check("a5_drained_valid", {31'd0, output_valid}, 32'd0);
        check("a5_drained_data", {24'd0, output_data}, 32'h00);

        // Empty FIFO with write and output_ready together: store only, no read.
        cyc(1'b1, 8'h5A, 1'b1);
        check("empty_wr_rd_valid", {31'd0, output_valid}, 32'd1);
        check("empty_wr_rd_data", {24'd0, output_data}, 32'h5A);
        cyc(1'b0, 8'h00, 1'b1);

        // Fill to DEPTH.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", {31'd0, input_ready}, 32'd1);
            cyc(1'b1, i[7:0], 1'b0);
        end
        check("full_ready", {31'd0, input_ready}, 32'd0);
        cyc(1'b1, 8'h80, 1'b0);
        check("full_reject_ready", {31'd0, input_ready}, 32'd0);
        check("full_head", {24'd0, output_data}, 32'h00);

        // Full: write and read offered together, only the read happens.
        cyc(1'b1, 8'hEE, 1'b1);
        check("full_rdwr_ready", {31'd0, input_ready}, 32'd1);
        check("full_rdwr_head", {24'd0, output_data}, 32'h01);
        cyc(1'b1, 8'hEE, 1'b0);
        check("refill_ready", {31'd0, input_ready}, 32'd0);

        for (int i = 1; i < DEPTH; i++) begin
            check("drain_data", {24'd0, output_data}, i);
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("drain_last", {24'd0, output_data}, 32'hEE);
        cyc(1'b0, 8'h00, 1'b1);
        check("drain_empty", {31'd0, output_valid}, 32'd0);

        // Streaming across pointer wrap.
        cyc(1'b1, 8'h00, 1'b1);
        for (int i = 1; i < 300; i++) begin
            check("stream_data", {24'd0, output_data}, (i - 1) % 256);
            cyc(1'b1, i[7:0], 1'b1);
        end
        check("stream_tail", {24'd0, output_data}, 32'd299 % 256);
        cyc(1'b0, 8'h00, 1'b1);
        check("stream_empty", {31'd0, output_valid}, 32'd0);

        // Reset with 5 words stored.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + i[7:0], 1'b0);
        check("pre_rst_head", {24'd0, output_data}, 32'hC0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, output_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, input_ready}, 32'd0);
        check("mid_rst_data", {24'd0, output_data}, 32'd0);
        input_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        check("after_rst_ready", {31'd0, input_ready}, 32'd1);
        check("after_rst_valid", {31'd0, output_valid}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
